fifo_datapath: RTL

//  Storage and pointer datapath that executes the FIFO controller's 5-bit control word and returns its 4-bit status word.

---
 rtl/fifo_datapath.sv | 99 +++++++++
 1 files changed

// File: rtl/fifo_datapath.sv
// rtl/fifo_datapath.sv - FIFO storage, wrap-bit pointers, output data and status/error reporting
module fifo_datapath #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int FWFT_ENABLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            control_signals,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [3:0]            status_signals,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  // Control word decode: {load_data, read_data, clr, r_adr_trigger, w_adr_trigger}
  logic load_data;
  logic read_data;
  logic clr;
  logic r_adr_trigger;
  logic w_adr_trigger;
  assign {load_data, read_data, clr, r_adr_trigger, w_adr_trigger} = control_signals;

  logic [ADDR_WIDTH:0]   w_ptr;
  logic [ADDR_WIDTH:0]   r_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic empty;
  logic full;
  logic wrap_differs;
  logic one_left;

  // Status is derived only from the registered pointers
  assign fill_level   = w_ptr - r_ptr;
  assign empty        = (w_ptr == r_ptr);
  assign wrap_differs = (w_ptr[ADDR_WIDTH] != r_ptr[ADDR_WIDTH]);
  // Low-bit match is qualified by the wrap bit so this flag never asserts on an empty FIFO
  assign full         = (w_ptr[ADDR_WIDTH-1:0] == r_ptr[ADDR_WIDTH-1:0]) && wrap_differs;
  assign one_left     = (fill_level == PTR_ONE);

  assign status_signals = {wrap_differs, full, one_left, empty};

  // Pointer advance and sticky error flags; clr wins over every other control bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_ptr         <= '0;
      r_ptr         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (clr) begin
      w_ptr         <= '0;
      r_ptr         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (w_adr_trigger) begin
        w_ptr <= w_ptr + PTR_ONE;
        if (full) overflow_err <= 1'b1;
      end
      if (r_adr_trigger) begin
        r_ptr <= r_ptr + PTR_ONE;
        if (empty) underflow_err <= 1'b1;
      end
    end
  end

  // RAM write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (load_data && !clr) mem[w_ptr[ADDR_WIDTH-1:0]] <= din;
  end

  generate
    if (FWFT_ENABLE != 0) begin : g_fwft
      // Head of queue is presented directly; read_data only matters for the registered path
      logic read_data_unused;
      assign read_data_unused = read_data;
      assign dout = empty ? '0 : mem[r_ptr[ADDR_WIDTH-1:0]];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;
      // Registered output: capture the head word on a qualified read, else hold
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dout_q <= '0;
        end else if (clr) begin
          dout_q <= '0;
        end else if (read_data && !empty) begin
          dout_q <= mem[r_ptr[ADDR_WIDTH-1:0]];
        end
      end
      assign dout = dout_q;
    end
  endgenerate

endmodule
